decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 170 +++++++++++++++++
 tb/tb_decode_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with register file, hazard tracker and forwarding selects
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   instr, instr_valid       fetched instruction {opcode, rd, ra, rb} and its valid flag
//   wb_en, wb_addr, wb_data  register file writeback from the last pipeline stage
//   stall                    combinational; fetch holds instr/instr_valid for the next cycle
//   is_add .. is_eq          registered one-hot ALU select
//   is_mem_read .. is_halt   registered pipeline controls
//   val1, val2, val3         registered R[ra], R[rb], R[rd]
//   is_val1_data_hazard,
//   is_val2_data_hazard,
//   is_mem_data_hazard       registered forwarding selects
module decode_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  input  logic              wb_en,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              is_add,
  output logic              is_sub,
  output logic              is_and,
  output logic              is_or,
  output logic              is_gt,
  output logic              is_eq,
  output logic              is_mem_read,
  output logic              is_mem_write,
  output logic              is_reg_write,
  output logic              is_branch,
  output logic              is_halt,
  output logic [DATA_W-1:0] val1,
  output logic [DATA_W-1:0] val2,
  output logic [DATA_W-1:0] val3,
  output logic              is_val1_data_hazard,
  output logic              is_val2_data_hazard,
  output logic              is_mem_data_hazard
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [3:0] op, rd, ra, rb;
  assign op = instr[15:12];
  assign rd = instr[11:8];
  assign ra = instr[7:4];
  assign rb = instr[3:0];

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] rf_q [16];
  logic [DATA_W-1:0] rf_d [16];
  logic [DATA_W-1:0] val1_q, val1_d, val2_q, val2_d, val3_q, val3_d;
  // {add, sub, and, or, gt, eq, mem_read, mem_write, reg_write, branch, halt, h1, h2, hmem}
  logic [13:0]       ctrl_q, ctrl_d;
  logic              d1_valid_q, d1_valid_d, d1_load_q, d1_load_d;
  logic              d2_valid_q, d2_valid_d, d2_load_q, d2_load_d;
  logic [3:0]        d1_addr_q, d1_addr_d, d2_addr_q, d2_addr_d;

  logic [10:0] dec;
  logic        reads_ab, reads_rd, dec_load;
  logic        m1_a, m2_a, m1_b, m2_b, rd_match, hz_stall, running, issue;
  logic [DATA_W-1:0] rd_a, rd_b, rd_d;

  // Decode table; bit order matches the upper 11 bits of ctrl.
  always_comb begin
    dec      = '0;
    reads_ab = 1'b0;
    reads_rd = 1'b0;
    dec_load = 1'b0;
    case (op)
      4'h1: dec = 11'b10000000100;
      4'h2: dec = 11'b01000000100;
      4'h3: dec = 11'b00100000100;
      4'h4: dec = 11'b00010000100;
      4'h5: dec = 11'b00001000100;
      4'h6: dec = 11'b00000100100;
      4'h7: begin dec = 11'b10000010100; dec_load = 1'b1; end
      4'h8: dec = 11'b10000001000;
      4'h9: dec = 11'b00000100010;
      4'hA: dec = 11'b00001000010;
      4'hF: dec = 11'b00000000001;
      default: dec = '0;
    endcase
    reads_ab = (op >= 4'h1) && (op <= 4'hA);
    reads_rd = (op >= 4'h8) && (op <= 4'hA);
  end

  // Register reads see a same-cycle writeback so the value is never one cycle stale.
  assign rd_a = (wb_en && wb_addr == ra) ? wb_data : rf_q[ra];
  assign rd_b = (wb_en && wb_addr == rb) ? wb_data : rf_q[rb];
  assign rd_d = (wb_en && wb_addr == rd) ? wb_data : rf_q[rd];

  // The nearer producer (d1) wins; a d2 match only counts when d1 did not match.
  assign m1_a = reads_ab && d1_valid_q && (d1_addr_q == ra);
  assign m2_a = reads_ab && !m1_a && d2_valid_q && (d2_addr_q == ra);
  assign m1_b = reads_ab && d1_valid_q && (d1_addr_q == rb);
  assign m2_b = reads_ab && !m1_b && d2_valid_q && (d2_addr_q == rb);
  assign rd_match = reads_rd && ((d1_valid_q && d1_addr_q == rd) ||
                                 (d2_valid_q && d2_addr_q == rd));

  // Stall on load-use from d1, on operands needing different forwarding sources
  // (only one forward path exists), or on a store/branch reading an in-flight rd.
  assign hz_stall = ((m1_a || m1_b) && d1_load_q) || (m1_a && m2_b) || (m2_a && m1_b) || rd_match;
  assign running  = (state_q == ST_RUN);
  assign issue    = running && instr_valid && !hz_stall;
  assign stall    = rst && (!running || (instr_valid && hz_stall));

  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_addr] = wb_data;

    ctrl_d = issue ? {dec, (m1_a || m2_a), (m1_b || m2_b),
                      ((m2_a || m2_b) && !(m1_a || m1_b))} : '0;
    val1_d = issue ? rd_a : val1_q;
    val2_d = issue ? rd_b : val2_q;
    val3_d = issue ? rd_d : val3_q;

    // Non-issuing cycles shift a bubble into the tracker.
    d1_valid_d = issue && dec[2];
    d1_load_d  = issue && dec_load;
    d1_addr_d  = rd;
    d2_valid_d = d1_valid_q;
    d2_load_d  = d1_load_q;
    d2_addr_d  = d1_addr_q;

    state_d = (issue && dec[0]) ? ST_HALTED : state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      ctrl_q     <= '0;
      val1_q     <= '0;
      val2_q     <= '0;
      val3_q     <= '0;
      d1_valid_q <= 1'b0;
      d1_load_q  <= 1'b0;
      d1_addr_q  <= '0;
      d2_valid_q <= 1'b0;
      d2_load_q  <= 1'b0;
      d2_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      ctrl_q     <= ctrl_d;
      val1_q     <= val1_d;
      val2_q     <= val2_d;
      val3_q     <= val3_d;
      d1_valid_q <= d1_valid_d;
      d1_load_q  <= d1_load_d;
      d1_addr_q  <= d1_addr_d;
      d2_valid_q <= d2_valid_d;
      d2_load_q  <= d2_load_d;
      d2_addr_q  <= d2_addr_d;
    end
  end

  assign {is_add, is_sub, is_and, is_or, is_gt, is_eq, is_mem_read, is_mem_write,
          is_reg_write, is_branch, is_halt,
          is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard} = ctrl_q;
  assign val1 = val1_q;
  assign val2 = val2_q;
  assign val3 = val3_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - directed self-checking bench for decode_stage
module tb_decode_stage;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [15:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic              wb_en = 1'b0;
  logic [3:0]        wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              stall;
  logic is_add, is_sub, is_and, is_or, is_gt, is_eq;
  logic is_mem_read, is_mem_write, is_reg_write, is_branch, is_halt;
  logic [DATA_W-1:0] val1, val2, val3;
  logic is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard;

  decode_stage #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .is_add(is_add), .is_sub(is_sub), .is_and(is_and), .is_or(is_or),
    .is_gt(is_gt), .is_eq(is_eq), .is_mem_read(is_mem_read),
    .is_mem_write(is_mem_write), .is_reg_write(is_reg_write),
    .is_branch(is_branch), .is_halt(is_halt),
    .val1(val1), .val2(val2), .val3(val3),
    .is_val1_data_hazard(is_val1_data_hazard),
    .is_val2_data_hazard(is_val2_data_hazard),
    .is_mem_data_hazard(is_mem_data_hazard)
  );

  always #5 clk = ~clk;

  // {add, sub, and, or, gt, eq, mem_read, mem_write, reg_write, branch, halt}
  wire [10:0] ctrl_v = {is_add, is_sub, is_and, is_or, is_gt, is_eq, is_mem_read,
                        is_mem_write, is_reg_write, is_branch, is_halt};
  // {val1 hazard, val2 hazard, mem hazard}
  wire [2:0]  haz_v  = {is_val1_data_hazard, is_val2_data_hazard, is_mem_data_hazard};

  localparam logic [10:0] C_NONE  = 11'b00000000000;
  localparam logic [10:0] C_ADD   = 11'b10000000100;
  localparam logic [10:0] C_SUB   = 11'b01000000100;
  localparam logic [10:0] C_LOAD  = 11'b10000010100;
  localparam logic [10:0] C_STORE = 11'b10000001000;
  localparam logic [10:0] C_BEQ   = 11'b00000100010;
  localparam logic [10:0] C_HALT  = 11'b00000000001;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {op, rd, ra, rb};
  endfunction

  // Drive one cycle of inputs, check combinational stall mid-cycle, then step past the edge.
  task automatic step(input logic [15:0] i, input logic v, input logic we,
                      input logic [3:0] wa, input logic [15:0] wd,
                      input logic exp_stall, input string tag);
    instr = i; instr_valid = v; wb_en = we; wb_addr = wa; wb_data = wd;
    #2;
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input string tag);
    step(16'h0000, 1'b0, 1'b0, 4'h0, 16'h0, 1'b0, tag);
  endtask

  initial begin
    // Reset with a HALT presented: stall must stay low, outputs cleared.
    instr = enc(4'hF, 0, 0, 0); instr_valid = 1'b1;
    #3;
    check("rst.stall", {31'd0, stall}, 0);
    check("rst.ctrl", {21'd0, ctrl_v}, 0);
    check("rst.val1", {16'd0, val1}, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    step(16'h0, 1'b0, 1'b1, 4'h1, 16'd5, 1'b0, "wb_r1");
    step(16'h0, 1'b0, 1'b1, 4'h2, 16'd3, 1'b0, "wb_r2");

    step(enc(4'h1, 3, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "add");
    check("add.ctrl", {21'd0, ctrl_v}, {21'd0, C_ADD});
    check("add.val1", {16'd0, val1}, 5);
    check("add.val2", {16'd0, val2}, 3);
    check("add.haz", {29'd0, haz_v}, 0);

    step(enc(4'h2, 4, 3, 1), 1'b1, 1'b0, 0, 0, 1'b0, "sub_fwd");
    check("sub.ctrl", {21'd0, ctrl_v}, {21'd0, C_SUB});
    check("sub.haz", {29'd0, haz_v}, 3'b100);
    check("sub.val2", {16'd0, val2}, 5);

    bubble("bub1");
    check("bub1.ctrl", {21'd0, ctrl_v}, 0);
    check("bub1.val2", {16'd0, val2}, 5);
    bubble("bub2");

    step(enc(4'h7, 5, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "load");
    check("load.ctrl", {21'd0, ctrl_v}, {21'd0, C_LOAD});
    step(enc(4'h1, 6, 5, 1), 1'b1, 1'b0, 0, 0, 1'b1, "loaduse");
    check("loaduse.ctrl", {21'd0, ctrl_v}, 0);
    check("loaduse.haz", {29'd0, haz_v}, 0);
    check("loaduse.val1", {16'd0, val1}, 5);
    step(enc(4'h1, 6, 5, 1), 1'b1, 1'b0, 0, 0, 1'b0, "loaduse2");
    check("loaduse2.ctrl", {21'd0, ctrl_v}, {21'd0, C_ADD});
    check("loaduse2.haz", {29'd0, haz_v}, 3'b101);
    check("loaduse2.val2", {16'd0, val2}, 5);
    bubble("bub3");
    bubble("bub4");

    step(enc(4'h1, 3, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "mix_a");
    step(enc(4'h1, 4, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "mix_b");
    check("mix_b.haz", {29'd0, haz_v}, 0);
    step(enc(4'h1, 7, 4, 3), 1'b1, 1'b0, 0, 0, 1'b1, "mix_c");
    check("mix_c.ctrl", {21'd0, ctrl_v}, 0);
    step(enc(4'h1, 7, 4, 3), 1'b1, 1'b1, 4'h3, 16'd9, 1'b0, "mix_d");
    check("mix_d.ctrl", {21'd0, ctrl_v}, {21'd0, C_ADD});
    check("mix_d.haz", {29'd0, haz_v}, 3'b101);
    check("mix_d.val2", {16'd0, val2}, 9);
    bubble("bub5");
    bubble("bub6");

    step(enc(4'h1, 8, 1, 2), 1'b1, 1'b1, 4'h2, 16'd7, 1'b0, "bypass");
    check("bypass.val1", {16'd0, val1}, 5);
    check("bypass.val2", {16'd0, val2}, 7);
    check("bypass.haz", {29'd0, haz_v}, 0);

    step(enc(4'h8, 8, 1, 2), 1'b1, 1'b0, 0, 0, 1'b1, "st_d1");
    check("st_d1.ctrl", {21'd0, ctrl_v}, 0);
    step(enc(4'h8, 8, 1, 2), 1'b1, 1'b0, 0, 0, 1'b1, "st_d2");
    step(enc(4'h8, 8, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "st_go");
    check("st_go.ctrl", {21'd0, ctrl_v}, {21'd0, C_STORE});
    check("st_go.val2", {16'd0, val2}, 7);
    check("st_go.val3", {16'd0, val3}, 0);

    step(enc(4'h9, 2, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "beq");
    check("beq.ctrl", {21'd0, ctrl_v}, {21'd0, C_BEQ});
    check("beq.val3", {16'd0, val3}, 7);

    step(16'h0, 1'b0, 1'b1, 4'h0, 16'd11, 1'b0, "wb_r0");
    step(enc(4'h1, 0, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "r0_wr");
    step(enc(4'h2, 10, 0, 0), 1'b1, 1'b0, 0, 0, 1'b0, "r0_use");
    check("r0_use.haz", {29'd0, haz_v}, 3'b110);
    check("r0_use.val1", {16'd0, val1}, 11);

    step(enc(4'hB, 1, 10, 10), 1'b1, 1'b0, 0, 0, 1'b0, "op_b");
    check("op_b.ctrl", {21'd0, ctrl_v}, 0);
    check("op_b.haz", {29'd0, haz_v}, 0);

    step(enc(4'hF, 0, 0, 0), 1'b1, 1'b0, 0, 0, 1'b0, "halt");
    check("halt.ctrl", {21'd0, ctrl_v}, {21'd0, C_HALT});
    check("halt.val1", {16'd0, val1}, 11);
    step(enc(4'h1, 3, 1, 2), 1'b1, 1'b0, 0, 0, 1'b1, "halted1");
    check("halted1.ctrl", {21'd0, ctrl_v}, 0);
    step(enc(4'h1, 3, 1, 2), 1'b1, 1'b0, 0, 0, 1'b1, "halted2");
    check("halted2.ctrl", {21'd0, ctrl_v}, 0);

    rst = 1'b0;
    #2;
    check("rst2.stall", {31'd0, stall}, 0);
    check("rst2.val1", {16'd0, val1}, 0);
    check("rst2.ctrl", {21'd0, ctrl_v}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step(enc(4'h1, 3, 1, 2), 1'b1, 1'b0, 0, 0, 1'b0, "post_rst");
    check("post_rst.ctrl", {21'd0, ctrl_v}, {21'd0, C_ADD});
    check("post_rst.val1", {16'd0, val1}, 0);
    check("post_rst.val2", {16'd0, val2}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
